spi_xfer_queue: RTL and testbench

- Sits directly upstream of spi_master, between the CPU peripheral register file and spi_master.
- Buffers outgoing words in a TX FIFO and launches one spi_master transfer per word via the tx_start/busy handshake.
- Captures each completed frame's rx_data into an RX FIFO for the CPU to read.
- Decouples software from per-frame timing so back-to-back frames run without CPU intervention.

---
 rtl/spi_xfer_queue_if.sv | 37 +++
 rtl/spi_xfer_queue.sv | 141 ++++++++++++++
 tb/tb_spi_xfer_queue.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_queue_if.sv
// Bundle of CPU-side queue signals and spi_master handshake signals for spi_xfer_queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface spi_xfer_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              enable;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              tx_full;
    logic [LVL_W-1:0]  tx_level;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rx_empty;
    logic [LVL_W-1:0]  rx_level;
    logic              rx_overflow;
    logic              clr_ovf;
    logic              active;
    logic              spi_tx_start;
    logic [DATA_W-1:0] spi_tx_data;
    logic              spi_busy;
    logic [DATA_W-1:0] spi_rx_data;

    modport slave (
        input  enable, wr_en, wr_data, rd_en, clr_ovf, spi_busy, spi_rx_data,
        output tx_full, tx_level, rd_data, rx_empty, rx_level, rx_overflow,
               active, spi_tx_start, spi_tx_data
    );

    modport master (
        output enable, wr_en, wr_data, rd_en, clr_ovf, spi_busy, spi_rx_data,
        input  tx_full, tx_level, rd_data, rx_empty, rx_level, rx_overflow,
               active, spi_tx_start, spi_tx_data
    );
endinterface

// File: rtl/spi_xfer_queue.sv
// TX/RX word queues in front of spi_master: launches one frame per queued TX word
// via the tx_start/busy handshake and stores each received word in the RX FIFO.
module spi_xfer_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    spi_xfer_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_XFER    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t            state_q;
    logic              start_q;
    logic              active_q;
    logic [DATA_W-1:0] txd_q;

    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [PTR_W-1:0]  tx_wptr_q, tx_rptr_q;
    logic [LVL_W-1:0]  tx_cnt_q, tx_cnt_d;

    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [PTR_W-1:0]  rx_wptr_q, rx_rptr_q;
    logic [LVL_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              ovf_q, ovf_d;

    logic tx_full_s, tx_pop_s, tx_push_s;
    logic rx_empty_s, rx_full_s, rx_pop_s, rx_push_s, rx_drop_s, capture_s;

    // FIFO handshakes; a same-cycle pop frees the slot a full-FIFO push needs
    always_comb begin
        tx_full_s  = (tx_cnt_q == LVL_W'(DEPTH));
        tx_pop_s   = (state_q == ST_IDLE) && bus.enable && (tx_cnt_q != {LVL_W{1'b0}});
        tx_push_s  = bus.wr_en && (!tx_full_s || tx_pop_s);
        rx_empty_s = (rx_cnt_q == {LVL_W{1'b0}});
        rx_full_s  = (rx_cnt_q == LVL_W'(DEPTH));
        rx_pop_s   = bus.rd_en && !rx_empty_s;
        capture_s  = (state_q == ST_CAPTURE);
        rx_push_s  = capture_s && (!rx_full_s || rx_pop_s);
        rx_drop_s  = capture_s && rx_full_s && !rx_pop_s;
        tx_cnt_d   = tx_cnt_q + LVL_W'(tx_push_s) - LVL_W'(tx_pop_s);
        rx_cnt_d   = rx_cnt_q + LVL_W'(rx_push_s) - LVL_W'(rx_pop_s);
        if (rx_drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage arrays, written without reset
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wptr_q] <= bus.wr_data;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= bus.spi_rx_data;
        end
    end

    // FIFO pointers, occupancy counters and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q <= {PTR_W{1'b0}};
            tx_rptr_q <= {PTR_W{1'b0}};
            tx_cnt_q  <= {LVL_W{1'b0}};
            rx_wptr_q <= {PTR_W{1'b0}};
            rx_rptr_q <= {PTR_W{1'b0}};
            rx_cnt_q  <= {LVL_W{1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            if (tx_push_s) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
            if (tx_pop_s)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
            if (rx_push_s) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
            if (rx_pop_s)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Frame sequencer; tx_data is latched on TX pop and held until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            active_q <= 1'b0;
            txd_q    <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_pop_s) begin
                        txd_q    <= tx_mem_q[tx_rptr_q];
                        start_q  <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (bus.spi_busy) begin
                        start_q <= 1'b0;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!bus.spi_busy) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    start_q  <= 1'b0;
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_full      = tx_full_s;
    assign bus.tx_level     = tx_cnt_q;
    assign bus.rx_empty     = rx_empty_s;
    assign bus.rx_level     = rx_cnt_q;
    assign bus.rd_data      = rx_mem_q[rx_rptr_q];
    assign bus.rx_overflow  = ovf_q;
    assign bus.active       = active_q;
    assign bus.spi_tx_start = start_q;
    assign bus.spi_tx_data  = txd_q;
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Randomized bench for spi_xfer_queue: a transaction-level queue model plus a
// behavioural spi_master stand-in with configurable busy delay and frame length.
module tb_spi_xfer_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_xfer_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();
    spi_xfer_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    bit          m_ovf;
    // spi_master stand-in
    int          ph, dly, blen, cap_cnt;
    bit          busy_first;
    logic [31:0] cur_word, rx_word;
    int          k_dly = -1, k_len = -1;
    bit          k_rx_set = 1'b0;
    logic [31:0] k_rx;
    bit          rd_on_cap = 1'b0;
    bit          gap_chk = 1'b0;
    int          n_frames = 0, cyc = 0, drop_cyc = 0;
    bit          prev_start = 1'b0;

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_ovf = 1'b0;
        ph = 0;
        cap_cnt = 0;
        prev_start = 1'b0;
        bus.spi_busy = 1'b0;
    endtask

    // One clock: inputs are stable from the previous negedge, model updated after the edge.
    task automatic step();
        bit s_wr, s_rd, s_clr, s_en, s_start, s_busy, s_rst;
        logic [31:0] s_wd;
        if (rd_on_cap && cap_cnt == 1) bus.rd_en = 1'b1;
        s_wr = bus.wr_en; s_rd = bus.rd_en; s_clr = bus.clr_ovf; s_en = bus.enable;
        s_start = bus.spi_tx_start; s_busy = bus.spi_busy; s_rst = rst; s_wd = bus.wr_data;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            model_reset();
        end else begin
            if (bus.spi_tx_start && !prev_start) begin
                check_val("launch_enable", 32'(s_en), 32'd1);
                cur_word = (m_tx.size() > 0) ? m_tx.pop_front() : 32'hxxxx_xxxx;
                check_val("launch_data", bus.spi_tx_data, cur_word);
                if (gap_chk && drop_cyc > 0) check_val("frame_gap", cyc - drop_cyc, 32'd3);
                n_frames++;
            end
            prev_start = bus.spi_tx_start;
            if (s_wr && m_tx.size() < DEPTH) m_tx.push_back(s_wd);
            if (s_rd && m_rx.size() > 0) void'(m_rx.pop_front());
            if (s_clr) m_ovf = 1'b0;
            if (cap_cnt > 0) begin
                cap_cnt--;
                if (cap_cnt == 0) begin
                    if (m_rx.size() < DEPTH) m_rx.push_back(rx_word);
                    else m_ovf = 1'b1;
                end
            end
            case (ph)
                0: if (s_start) begin
                    dly = (k_dly >= 0) ? k_dly : int'($urandom_range(0, 3));
                    ph = 1;
                    check_val("start_hold", 32'(bus.spi_tx_start), 32'd1);
                    if (dly == 0) begin
                        bus.spi_busy = 1'b1; busy_first = 1'b1; ph = 2;
                        blen = (k_len >= 0) ? k_len : int'($urandom_range(1, 4));
                    end
                end
                1: begin
                    check_val("start_hold", 32'(bus.spi_tx_start), 32'd1);
                    dly--;
                    if (dly == 0) begin
                        bus.spi_busy = 1'b1; busy_first = 1'b1; ph = 2;
                        blen = (k_len >= 0) ? k_len : int'($urandom_range(1, 4));
                    end
                end
                2: begin
                    if (busy_first) check_val("start_drop", 32'(bus.spi_tx_start), 32'd0);
                    busy_first = 1'b0;
                    check_val("data_stable", bus.spi_tx_data, cur_word);
                    blen--;
                    if (blen <= 0) begin
                        bus.spi_busy = 1'b0;
                        rx_word = k_rx_set ? k_rx : $urandom;
                        bus.spi_rx_data = rx_word;
                        cap_cnt = 2;
                        drop_cyc = cyc;
                        ph = 0;
                    end
                end
                default: ph = 0;
            endcase
        end
        check_val("tx_level", 32'(bus.tx_level), m_tx.size());
        check_val("tx_full", 32'(bus.tx_full), 32'(m_tx.size() == DEPTH));
        check_val("rx_level", 32'(bus.rx_level), m_rx.size());
        check_val("rx_empty", 32'(bus.rx_empty), 32'(m_rx.size() == 0));
        check_val("rx_overflow", 32'(bus.rx_overflow), 32'(m_ovf));
        if (m_rx.size() > 0) check_val("rd_data", bus.rd_data, m_rx[0]);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0;
    endtask

    function automatic bit model_busy();
        return (ph != 0) || (cap_cnt != 0) || (bus.enable && m_tx.size() > 0) || bus.spi_tx_start;
    endfunction

    task automatic drain(input int budget);
        for (int i = 0; i < budget && model_busy(); i++) step();
        check_val("drained", 32'(model_busy()), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.wr_en = 1'b1;
        bus.wr_data = w;
        step();
    endtask

    task automatic read_all();
        for (int i = 0; i < 2 * DEPTH && m_rx.size() > 0; i++) begin
            bus.rd_en = 1'b1;
            step();
        end
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0; bus.spi_busy = 1'b0; bus.spi_rx_data = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_val("rst_active", 32'(bus.active), 32'd0);
        check_val("rst_start", 32'(bus.spi_tx_start), 32'd0);
        check_val("rst_txdata", bus.spi_tx_data, 32'd0);

        // first frame: launch timing and RX capture
        k_dly = 0; k_len = 2; k_rx_set = 1'b1; k_rx = 32'h0000_00A5;
        bus.enable = 1'b1;
        push_word(32'h72);
        check_val("t1_start_early", 32'(bus.spi_tx_start), 32'd0);
        step();
        check_val("t1_start", 32'(bus.spi_tx_start), 32'd1);
        check_val("t1_data", bus.spi_tx_data, 32'h72);
        check_val("t1_active", 32'(bus.active), 32'd1);
        drain(50);
        check_val("t1_rd", bus.rd_data, 32'hA5);
        check_val("t1_rxlvl", 32'(bus.rx_level), 32'd1);
        read_all();

        // fill TX while held, 5th word dropped, then back-to-back frames
        k_rx_set = 1'b0;
        bus.enable = 1'b0;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        push_word(32'h55);
        check_val("t2_full", 32'(bus.tx_full), 32'd1);
        check_val("t2_level", 32'(bus.tx_level), 32'd4);
        drop_cyc = 0; gap_chk = 1'b1; f0 = n_frames;
        bus.enable = 1'b1;
        drain(100);
        gap_chk = 1'b0;
        check_val("t2_frames", n_frames - f0, 32'd4);

        // five frames, no reads: overflow
        read_all();
        for (int i = 0; i < 5; i++) push_word(32'h100 + i);
        drain(200);
        check_val("t3_rxlvl", 32'(bus.rx_level), 32'd4);
        check_val("t3_ovf", 32'(bus.rx_overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        step();
        check_val("t3_clr", 32'(bus.rx_overflow), 32'd0);

        // RX full, pop exactly in the capture cycle
        rd_on_cap = 1'b1;
        k_rx_set = 1'b1; k_rx = 32'hCAFE_0001;
        push_word(32'h77);
        drain(50);
        rd_on_cap = 1'b0; k_rx_set = 1'b0;
        check_val("t4_rxlvl", 32'(bus.rx_level), 32'd4);
        check_val("t4_ovf", 32'(bus.rx_overflow), 32'd0);
        read_all();

        // slow busy response
        k_dly = 3; f0 = n_frames;
        push_word(32'hBEEF);
        drain(50);
        check_val("t5_frames", n_frames - f0, 32'd1);
        k_dly = 0;

        // reset in the middle of a frame with two words queued
        bus.enable = 1'b0;
        push_word(32'h1); push_word(32'h2); push_word(32'h3);
        k_len = 20;
        bus.enable = 1'b1;
        for (int i = 0; i < 20 && ph != 2; i++) step();
        step();
        check_val("t6_queued", 32'(bus.tx_level), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_txlvl", 32'(bus.tx_level), 32'd0);
        check_val("t6_active", 32'(bus.active), 32'd0);
        check_val("t6_start", 32'(bus.spi_tx_start), 32'd0);
        check_val("t6_rxempty", 32'(bus.rx_empty), 32'd1);

        // random traffic
        k_dly = -1; k_len = -1;
        for (int i = 0; i < 3000; i++) begin
            bus.enable  = ($urandom_range(0, 7) != 0);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_data = $urandom;
            bus.rd_en   = ($urandom_range(0, 3) == 0);
            bus.clr_ovf = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            step();
            rst = 1'b0;
        end
        bus.enable = 1'b1;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
